pipeline_hazard_responder: RTL and testbench

- Consumes the 11-bit one-hot hazard vector and the stall request produced by the control hazard unit each cycle.
- Turns them into pipeline actions:
  - registered forwarding-mux selects for the EX stage (ALU A/B, store data, branch compare, R0),
  - PC / IF-ID hold and ID/EX bubble insertion,
  - IF-ID flush on taken branches.
- Sits between the hazard unit and the pipeline registers/forwarding muxes of the datapath top level.

---
 rtl/types_pkg.sv | 37 +++
 rtl/hazard_fwd_decode.sv | 24 ++
 rtl/pipeline_hazard_responder.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared hazard/forwarding types and hazard-vector bit indices
package types_pkg;

   typedef enum logic [1:0] {
      FWD_NONE  = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hz_state_t;

   // S2 = producer in EX/MEM, S3 = producer in MEM/WB
   localparam int HAZ_A_S3      = 0;
   localparam int HAZ_A_S2      = 1;
   localparam int HAZ_B_S2      = 2;
   localparam int HAZ_B_S3      = 3;
   localparam int HAZ_CMP_S2    = 4;
   localparam int HAZ_CMP_S3    = 5;
   localparam int HAZ_R0_S2     = 6;
   localparam int HAZ_R0_S3     = 7;
   localparam int HAZ_ST_S2     = 8;
   localparam int HAZ_ST_S3     = 9;
   localparam int HAZ_ST_ALU_S2 = 10;

   localparam int HAZ_W = 11;

   function automatic fwd_sel_t pick_fwd(input logic near, input logic far);
      if (near)     return FWD_EXMEM;
      else if (far) return FWD_MEMWB;
      else          return FWD_NONE;
   endfunction

endpackage

// File: rtl/hazard_fwd_decode.sv
// rtl/hazard_fwd_decode.sv - combinational hazard vector to forwarding-select decode
module hazard_fwd_decode
   import types_pkg::*;
(
   input  logic [HAZ_W-1:0] haz,
   output fwd_sel_t         fwd_a_nx,
   output fwd_sel_t         fwd_b_nx,
   output fwd_sel_t         fwd_st_nx,
   output fwd_sel_t         fwd_cmp_nx,
   output fwd_sel_t         fwd_r0_nx,
   output logic             multi
);

   always_comb begin
      fwd_a_nx   = pick_fwd(haz[HAZ_A_S2], haz[HAZ_A_S3]);
      fwd_b_nx   = pick_fwd(haz[HAZ_B_S2], haz[HAZ_B_S3]);
      fwd_st_nx  = pick_fwd(haz[HAZ_ST_S2] | haz[HAZ_ST_ALU_S2], haz[HAZ_ST_S3]);
      fwd_cmp_nx = pick_fwd(haz[HAZ_CMP_S2], haz[HAZ_CMP_S3]);
      fwd_r0_nx  = pick_fwd(haz[HAZ_R0_S2], haz[HAZ_R0_S3]);
      // clearing the lowest set bit leaves something only if two or more were set
      multi      = |(haz & (haz - 11'd1));
   end

endmodule

// File: rtl/pipeline_hazard_responder.sv
// rtl/pipeline_hazard_responder.sv - turns hazard vector and stall/branch events into pipeline control
module pipeline_hazard_responder
   import types_pkg::*;
#(
   parameter int STALL_CYCLES = 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [HAZ_W-1:0]  haz,
   input  logic              stall_req,
   input  logic              branch_taken,
   input  logic              ext_hold,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output fwd_sel_t          fwd_a_sel,
   output fwd_sel_t          fwd_b_sel,
   output fwd_sel_t          fwd_st_sel,
   output fwd_sel_t          fwd_cmp_sel,
   output fwd_sel_t          fwd_r0_sel,
   output logic              haz_multi,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [2:0]       STALL_LOAD = 3'(STALL_CYCLES - 1);
   localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   hz_state_t  state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic       bubble;

   fwd_sel_t   fwd_a_nx, fwd_b_nx, fwd_st_nx, fwd_cmp_nx, fwd_r0_nx;
   logic       multi;

   hazard_fwd_decode u_decode (
      .haz        (haz),
      .fwd_a_nx   (fwd_a_nx),
      .fwd_b_nx   (fwd_b_nx),
      .fwd_st_nx  (fwd_st_nx),
      .fwd_cmp_nx (fwd_cmp_nx),
      .fwd_r0_nx  (fwd_r0_nx),
      .multi      (multi)
   );

   // branch_taken is checked first everywhere so a simultaneous stall request is dropped
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         RUN: begin
            if (branch_taken) begin
               state_nx = FLUSH;
               cnt_nx   = FLUSH_LOAD;
            end else if (stall_req) begin
               state_nx = STALL;
               cnt_nx   = STALL_LOAD;
            end
         end
         STALL, FLUSH: begin
            if (branch_taken) begin
               state_nx = FLUSH;
               cnt_nx   = FLUSH_LOAD;
            end else if (cnt == 3'd0) begin
               state_nx = RUN;
            end else begin
               cnt_nx = cnt - 3'd1;
            end
         end
         default: begin
            state_nx = RUN;
            cnt_nx   = 3'd0;
         end
      endcase
   end

   assign bubble = (state != RUN) || (state_nx != RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         cnt         <= 3'd0;
         fwd_a_sel   <= FWD_NONE;
         fwd_b_sel   <= FWD_NONE;
         fwd_st_sel  <= FWD_NONE;
         fwd_cmp_sel <= FWD_NONE;
         fwd_r0_sel  <= FWD_NONE;
         haz_multi   <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else if (!ext_hold) begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (bubble) begin
            fwd_a_sel   <= FWD_NONE;
            fwd_b_sel   <= FWD_NONE;
            fwd_st_sel  <= FWD_NONE;
            fwd_cmp_sel <= FWD_NONE;
            fwd_r0_sel  <= FWD_NONE;
         end else begin
            fwd_a_sel   <= fwd_a_nx;
            fwd_b_sel   <= fwd_b_nx;
            fwd_st_sel  <= fwd_st_nx;
            fwd_cmp_sel <= fwd_cmp_nx;
            fwd_r0_sel  <= fwd_r0_nx;
         end
         if (multi)
            haz_multi <= 1'b1;
         if (state == STALL && stall_cnt != CNT_MAX)
            stall_cnt <= stall_cnt + CNT_ONE;
         if (state == FLUSH && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + CNT_ONE;
      end
   end

   always_comb begin
      pc_en       = !ext_hold && (state != STALL);
      ifid_en     = !ext_hold && (state != STALL);
      ifid_flush  = !ext_hold && (state == FLUSH);
      idex_bubble = !ext_hold && (state != RUN);
   end

endmodule

// File: tb/tb_pipeline_hazard_responder.sv
// tb/tb_pipeline_hazard_responder.sv - self-checking bench for pipeline_hazard_responder
module tb_pipeline_hazard_responder;

   localparam int STALL_CYCLES = 1;
   localparam int FLUSH_CYCLES = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] haz = '0;
   logic        stall_req = 1'b0;
   logic        branch_taken = 1'b0;
   logic        ext_hold = 1'b0;

   logic        pc_en, ifid_en, ifid_flush, idex_bubble, haz_multi;
   logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_st_sel, fwd_cmp_sel, fwd_r0_sel;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_haz_multi;
   logic [1:0]  s_fa, s_fb, s_fst, s_fcmp, s_fr0;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   int tests = 0;
   int fails = 0;

   // reference state: remaining bubble cycles, unbounded event counts
   int m_sl = 0, m_fl = 0, m_sc = 0, m_fc = 0;
   int m_fa = 0, m_fb = 0, m_fst = 0, m_fcmp = 0, m_fr0 = 0;
   bit m_multi = 0;

   always #5 clk = ~clk;

   pipeline_hazard_responder #(.STALL_CYCLES(STALL_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .haz(haz), .stall_req(stall_req), .branch_taken(branch_taken),
      .ext_hold(ext_hold), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .fwd_st_sel(fwd_st_sel), .fwd_cmp_sel(fwd_cmp_sel), .fwd_r0_sel(fwd_r0_sel),
      .haz_multi(haz_multi), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_responder #(.STALL_CYCLES(STALL_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .haz(haz), .stall_req(stall_req), .branch_taken(branch_taken),
      .ext_hold(ext_hold), .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
      .idex_bubble(s_idex_bubble), .fwd_a_sel(s_fa), .fwd_b_sel(s_fb),
      .fwd_st_sel(s_fst), .fwd_cmp_sel(s_fcmp), .fwd_r0_sel(s_fr0),
      .haz_multi(s_haz_multi), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sel(input bit near, input bit far);
      return near ? 1 : (far ? 2 : 0);
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_edge();
      bit was_bubble;
      if (rst) begin
         m_sl = 0; m_fl = 0; m_sc = 0; m_fc = 0; m_multi = 0;
         m_fa = 0; m_fb = 0; m_fst = 0; m_fcmp = 0; m_fr0 = 0;
      end else if (!ext_hold) begin
         was_bubble = (m_sl > 0) || (m_fl > 0);
         if (m_fl > 0) m_fc++;
         else if (m_sl > 0) m_sc++;
         if ($countones(haz) > 1) m_multi = 1;
         if (branch_taken) begin
            m_fl = FLUSH_CYCLES;
            m_sl = 0;
         end else if (m_fl > 0) m_fl--;
         else if (m_sl > 0) m_sl--;
         else if (stall_req) m_sl = STALL_CYCLES;
         if (was_bubble || m_sl > 0 || m_fl > 0) begin
            m_fa = 0; m_fb = 0; m_fst = 0; m_fcmp = 0; m_fr0 = 0;
         end else begin
            m_fa   = sel(haz[1], haz[0]);
            m_fb   = sel(haz[2], haz[3]);
            m_fst  = sel(haz[8] | haz[10], haz[9]);
            m_fcmp = sel(haz[4], haz[5]);
            m_fr0  = sel(haz[6], haz[7]);
         end
      end
   endtask

   task automatic check_all();
      bit in_stall, in_flush;
      in_flush = (m_fl > 0);
      in_stall = (m_sl > 0) && !in_flush;
      chk("pc_en",       pc_en,       !ext_hold && !in_stall);
      chk("ifid_en",     ifid_en,     !ext_hold && !in_stall);
      chk("ifid_flush",  ifid_flush,  !ext_hold && in_flush);
      chk("idex_bubble", idex_bubble, !ext_hold && (in_stall || in_flush));
      chk("fwd_a_sel",   fwd_a_sel,   m_fa);
      chk("fwd_b_sel",   fwd_b_sel,   m_fb);
      chk("fwd_st_sel",  fwd_st_sel,  m_fst);
      chk("fwd_cmp_sel", fwd_cmp_sel, m_fcmp);
      chk("fwd_r0_sel",  fwd_r0_sel,  m_fr0);
      chk("haz_multi",   haz_multi,   m_multi);
      chk("stall_cnt",   stall_cnt,   sat(m_sc, 65535));
      chk("flush_cnt",   flush_cnt,   sat(m_fc, 65535));
      chk("sat_stall_cnt", s_stall_cnt, sat(m_sc, 15));
      chk("sat_flush_cnt", s_flush_cnt, sat(m_fc, 15));
   endtask

   task automatic step(input logic [10:0] h, input logic sr, input logic bt, input logic hold);
      haz = h; stall_req = sr; branch_taken = bt; ext_hold = hold;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   logic [10:0] rh;

   initial begin
      // reset with pending hazard and stall request
      rst = 1'b1;
      step(11'h002, 1'b1, 1'b0, 1'b0);
      step(11'h002, 1'b1, 1'b0, 1'b0);
      chk("reset_pc_en", pc_en, 1);
      chk("reset_stall_cnt", stall_cnt, 0);
      rst = 1'b0;

      // forwarding latency on operand A
      step(11'h002, 1'b0, 1'b0, 1'b0);
      chk("fwd_a_exmem", fwd_a_sel, 1);
      step(11'h001, 1'b0, 1'b0, 1'b0);
      chk("fwd_a_memwb", fwd_a_sel, 2);
      step(11'h000, 1'b0, 1'b0, 1'b0);
      chk("fwd_a_none", fwd_a_sel, 0);

      // single-cycle stall
      step(11'h000, 1'b1, 1'b0, 1'b0);
      chk("stall_pc_en", pc_en, 0);
      step(11'h000, 1'b0, 1'b0, 1'b0);
      chk("stall_done_cnt", stall_cnt, 1);

      // branch beats stall, then an extended flush
      step(11'h000, 1'b1, 1'b1, 1'b0);
      step(11'h000, 1'b0, 1'b0, 1'b0);
      step(11'h000, 1'b0, 1'b0, 1'b0);
      chk("branch_flush_cnt", flush_cnt, 2);
      chk("branch_stall_cnt", stall_cnt, 1);
      step(11'h000, 1'b0, 1'b1, 1'b0);
      step(11'h000, 1'b0, 1'b1, 1'b0);
      step(11'h000, 1'b0, 1'b0, 1'b0);
      step(11'h000, 1'b0, 1'b0, 1'b0);
      chk("ext_flush_cnt", flush_cnt, 5);

      // hold in the middle of a stall
      step(11'h000, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(11'h004, 1'b0, 1'b0, 1'b1);
      step(11'h000, 1'b0, 1'b0, 1'b0);
      chk("hold_stall_cnt", stall_cnt, 2);

      // multi-hot flag is sticky
      step(11'h003, 1'b0, 1'b0, 1'b0);
      chk("multi_fwd_a", fwd_a_sel, 1);
      step(11'h000, 1'b0, 1'b0, 1'b0);
      chk("multi_sticky", haz_multi, 1);

      // saturate the narrow counter
      for (int i = 0; i < 40; i++) step(11'h000, 1'b1, 1'b0, 1'b0);
      chk("sat_at_15", s_stall_cnt, 15);

      rst = 1'b1;
      step(11'h000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      chk("multi_cleared", haz_multi, 0);

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: rh = 11'(1 << $urandom_range(0, 10));
            5, 6, 7:       rh = 11'h000;
            default:       rh = 11'($urandom);
         endcase
         rst = ($urandom_range(0, 99) == 0);
         step(rh, ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 7) == 0));
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
